// File: rtl/z80ram_arbiter_if.sv
// z80ram_arbiter_if
// Bundles the two requester ports (Z80 and host) and the SRAM strobe/data
// pins of the work-RAM arbiter.
//   Z80_*  : level request, write flag, address, write data in; read data and
//            one-cycle ACK out.
//   HOST_* : same semantics as Z80_* for the host/loader port.
//   RAM_*  : SRAM address, read bus in, write data + drive enable out.
//   nCE/nOE/nWE : active-low SRAM strobes. BUSY : arbiter not idle.
// modport slave  : the arbiter's view.
// modport master : the requesters' and SRAM's view.
interface z80ram_arbiter_if;
  logic        Z80_REQ;
  logic        Z80_WR;
  logic [10:0] Z80_ADDR;
  logic [7:0]  Z80_WDATA;
  logic [7:0]  Z80_RDATA;
  logic        Z80_ACK;

  logic        HOST_REQ;
  logic        HOST_WR;
  logic [10:0] HOST_ADDR;
  logic [7:0]  HOST_WDATA;
  logic [7:0]  HOST_RDATA;
  logic        HOST_ACK;

  logic [10:0] RAM_ADDR;
  logic [7:0]  RAM_DIN;
  logic [7:0]  RAM_DOUT;
  logic        RAM_DOE;
  logic        nCE;
  logic        nOE;
  logic        nWE;
  logic        BUSY;

  modport slave (
    input  Z80_REQ, Z80_WR, Z80_ADDR, Z80_WDATA,
    output Z80_RDATA, Z80_ACK,
    input  HOST_REQ, HOST_WR, HOST_ADDR, HOST_WDATA,
    output HOST_RDATA, HOST_ACK,
    output RAM_ADDR, RAM_DOUT, RAM_DOE, nCE, nOE, nWE, BUSY,
    input  RAM_DIN
  );

  modport master (
    output Z80_REQ, Z80_WR, Z80_ADDR, Z80_WDATA,
    input  Z80_RDATA, Z80_ACK,
    output HOST_REQ, HOST_WR, HOST_ADDR, HOST_WDATA,
    input  HOST_RDATA, HOST_ACK,
    input  RAM_ADDR, RAM_DOUT, RAM_DOE, nCE, nOE, nWE, BUSY,
    output RAM_DIN
  );
endinterface

// File: rtl/z80ram_arbiter.sv
// z80ram_arbiter
// Shares a 2 KiB x 8 asynchronous SRAM between the Z80 bus interface and a
// host/loader port. Each granted request/ACK transaction is turned into a
// timed nCE/nOE/nWE strobe sequence; every output is registered.
// Ports:
//   CLK   : system clock, rising edge.
//   RESET : asynchronous, active-high; forces all strobes inactive at once.
//   bus   : z80ram_arbiter_if.slave (requester ports, SRAM pins, BUSY).
// Parameters:
//   RD_CYCLES : cycles nCE+nOE are held low for a read (>= 1).
//   WR_CYCLES : cycles nWE is held low for a write (>= 1).
module z80ram_arbiter #(
  parameter int RD_CYCLES = 3,
  parameter int WR_CYCLES = 2
) (
  input logic               CLK,
  input logic               RESET,
  z80ram_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  localparam logic [7:0] RD_LOAD = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_LOAD = 8'(WR_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        owner;      // 1 = host owns the current transaction
  logic        last_host;  // 1 = host was granted last (reset: Z80 wins ties)

  logic        grant;
  logic        grant_host;
  logic        sel_wr;
  logic [10:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        rd_done;

  assign rd_done = (state == RD) && (cnt == 8'd0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    grant      = 1'b0;
    grant_host = 1'b0;

    case (state)
      IDLE: begin
        if (bus.Z80_REQ || bus.HOST_REQ) begin
          grant      = 1'b1;
          grant_host = bus.HOST_REQ && (!bus.Z80_REQ || !last_host);
        end
      end
      RD: begin
        if (cnt == 8'd0) state_nxt = RECOVER;
        else             cnt_nxt   = cnt - 8'd1;
      end
      WR_SETUP: begin
        state_nxt = WR_PULSE;
        cnt_nxt   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == 8'd0) state_nxt = WR_HOLD;
        else             cnt_nxt   = cnt - 8'd1;
      end
      WR_HOLD: state_nxt = RECOVER;
      RECOVER: begin
        state_nxt = IDLE;
        // The owner is still holding REQ during its ACK cycle, so only the
        // other requester may be granted straight from RECOVER. It is the
        // round-robin winner anyway, and this keeps the nCE-high gap at one
        // cycle under back-to-back contention.
        if (owner ? bus.Z80_REQ : bus.HOST_REQ) begin
          grant      = 1'b1;
          grant_host = !owner;
        end
      end
      default: state_nxt = IDLE;
    endcase

    sel_wr    = grant_host ? bus.HOST_WR    : bus.Z80_WR;
    sel_addr  = grant_host ? bus.HOST_ADDR  : bus.Z80_ADDR;
    sel_wdata = grant_host ? bus.HOST_WDATA : bus.Z80_WDATA;

    if (grant) begin
      state_nxt = sel_wr ? WR_SETUP : RD;
      cnt_nxt   = RD_LOAD;
    end
  end

  // Strobes, ACKs and BUSY are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      owner          <= 1'b0;
      last_host      <= 1'b1;
      bus.RAM_ADDR   <= 11'd0;
      bus.RAM_DOUT   <= 8'd0;
      bus.RAM_DOE    <= 1'b0;
      bus.nCE        <= 1'b1;
      bus.nOE        <= 1'b1;
      bus.nWE        <= 1'b1;
      bus.BUSY       <= 1'b0;
      bus.Z80_ACK    <= 1'b0;
      bus.HOST_ACK   <= 1'b0;
      bus.Z80_RDATA  <= 8'h00;
      bus.HOST_RDATA <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;

      if (grant) begin
        owner        <= grant_host;
        last_host    <= grant_host;
        bus.RAM_ADDR <= sel_addr;
        bus.RAM_DOUT <= sel_wdata;
      end

      if (rd_done) begin
        if (owner) bus.HOST_RDATA <= bus.RAM_DIN;
        else       bus.Z80_RDATA  <= bus.RAM_DIN;
      end

      bus.nCE      <= !(state_nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
      bus.nOE      <= !(state_nxt == RD);
      bus.nWE      <= !(state_nxt == WR_PULSE);
      bus.RAM_DOE  <= state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD};
      bus.BUSY     <= (state_nxt != IDLE);
      // No grant happens on the way into RECOVER, so owner is current here.
      bus.Z80_ACK  <= (state_nxt == RECOVER) && !owner;
      bus.HOST_ACK <= (state_nxt == RECOVER) &&  owner;
    end
  end

endmodule

// File: tb/tb_z80ram_arbiter.sv
module tb_z80ram_arbiter;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  z80ram_arbiter_if bus ();

  z80ram_arbiter #(.RD_CYCLES(3), .WR_CYCLES(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural SRAM: reads while selected and output-enabled, writes on the
  // rising edge of nWE while selected and the bus is driven.
  logic [7:0] mem [2048];
  assign bus.RAM_DIN = (!bus.nCE && !bus.nOE) ? mem[bus.RAM_ADDR] : 8'hFF;
  always @(posedge bus.nWE) begin
    if (bus.nCE === 1'b0 && bus.RAM_DOE === 1'b1) mem[bus.RAM_ADDR] = bus.RAM_DOUT;
  end

  // Strobe invariants, sampled on every falling edge throughout the run.
  always @(negedge CLK) begin
    checks++;
    if ((bus.nOE === 1'b0 && bus.nWE === 1'b0) || (bus.RAM_DOE === 1'b1 && bus.nOE === 1'b0)) begin
      errors++;
      $display("FAIL strobe_invariant: nOE=%b nWE=%b RAM_DOE=%b at %0t",
               bus.nOE, bus.nWE, bus.RAM_DOE, $time);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
    tick();
  endtask

  // Runs one transaction and measures it; cycle 1 is the first cycle the
  // arbiter is busy after the grant edge.
  task automatic run_txn(input bit host, input bit wr, input logic [10:0] addr,
                         input logic [7:0] wdata,
                         output int ack_cyc, output int oe_low, output int we_low,
                         output int doe_cyc, output int first_we, output int other_ack,
                         output logic [7:0] rdata);
    int cyc;
    bit started;
    ack_cyc = 0; oe_low = 0; we_low = 0; doe_cyc = 0; first_we = 0; other_ack = 0;
    rdata = 8'hxx; cyc = 0; started = 0;
    if (host) begin
      bus.HOST_REQ = 1'b1; bus.HOST_WR = wr; bus.HOST_ADDR = addr; bus.HOST_WDATA = wdata;
    end else begin
      bus.Z80_REQ = 1'b1; bus.Z80_WR = wr; bus.Z80_ADDR = addr; bus.Z80_WDATA = wdata;
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!started && bus.BUSY) started = 1;
      if (started) cyc++;
      if (!bus.nOE) oe_low++;
      if (!bus.nWE) begin
        we_low++;
        if (first_we == 0) first_we = cyc;
      end
      if (bus.RAM_DOE) doe_cyc++;
      if (host ? bus.Z80_ACK : bus.HOST_ACK) other_ack++;
      if (host ? bus.HOST_ACK : bus.Z80_ACK) begin
        ack_cyc = cyc;
        rdata = host ? bus.HOST_RDATA : bus.Z80_RDATA;
        bus.HOST_REQ = 1'b0;
        bus.Z80_REQ  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (bus.nCE !== 1'b1) begin errors++; $display("FAIL reset_nCE: got %b expected 1", bus.nCE); end
    checks++; if (bus.nOE !== 1'b1) begin errors++; $display("FAIL reset_nOE: got %b expected 1", bus.nOE); end
    checks++; if (bus.nWE !== 1'b1) begin errors++; $display("FAIL reset_nWE: got %b expected 1", bus.nWE); end
    checks++; if (bus.RAM_DOE !== 1'b0) begin errors++; $display("FAIL reset_doe: got %b expected 0", bus.RAM_DOE); end
    checks++; if (bus.Z80_ACK !== 1'b0 || bus.HOST_ACK !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b expected 00", bus.Z80_ACK, bus.HOST_ACK); end
    checks++; if (bus.Z80_RDATA !== 8'h00) begin errors++; $display("FAIL reset_z80_rdata: got %h expected 00", bus.Z80_RDATA); end
    checks++; if (bus.HOST_RDATA !== 8'h00) begin errors++; $display("FAIL reset_host_rdata: got %h expected 00", bus.HOST_RDATA); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.RAM_ADDR !== 11'd0 || bus.RAM_DOUT !== 8'd0) begin errors++; $display("FAIL reset_addr_dout: got %h/%h expected 000/00", bus.RAM_ADDR, bus.RAM_DOUT); end
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_z80_read();
    int ack_cyc, oe_low, we_low, doe_cyc, first_we, other_ack;
    logic [7:0] rdata;
    mem[11'h123] = 8'h23;
    run_txn(1'b0, 1'b0, 11'h123, 8'h00, ack_cyc, oe_low, we_low, doe_cyc, first_we, other_ack, rdata);
    checks++; if (oe_low !== 3) begin errors++; $display("FAIL rd_oe_low_cycles: got %0d expected 3", oe_low); end
    checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL rd_ack_cycle: got %0d expected 4", ack_cyc); end
    checks++; if (rdata !== 8'h23) begin errors++; $display("FAIL rd_z80_rdata: got %h expected 23", rdata); end
    checks++; if (other_ack !== 0) begin errors++; $display("FAIL rd_host_ack: got %0d pulses expected 0", other_ack); end
    checks++; if (we_low !== 0 || doe_cyc !== 0) begin errors++; $display("FAIL rd_no_write_strobes: got we=%0d doe=%0d expected 0/0", we_low, doe_cyc); end
    tick();
    tick();
    checks++; if (bus.Z80_RDATA !== 8'h23 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL rd_rdata_hold_idle: got %h busy=%b expected 23 busy=0", bus.Z80_RDATA, bus.BUSY); end
  endtask

  task automatic test_host_write();
    int ack_cyc, oe_low, we_low, doe_cyc, first_we, other_ack;
    logic [7:0] rdata;
    mem[11'h7FF] = 8'h00;
    run_txn(1'b1, 1'b1, 11'h7FF, 8'hA5, ack_cyc, oe_low, we_low, doe_cyc, first_we, other_ack, rdata);
    checks++; if (doe_cyc !== 4) begin errors++; $display("FAIL wr_doe_cycles: got %0d expected 4", doe_cyc); end
    checks++; if (we_low !== 2) begin errors++; $display("FAIL wr_we_low_cycles: got %0d expected 2", we_low); end
    checks++; if (first_we !== 2) begin errors++; $display("FAIL wr_we_start_cycle: got %0d expected 2", first_we); end
    checks++; if (ack_cyc !== 5) begin errors++; $display("FAIL wr_ack_cycle: got %0d expected 5", ack_cyc); end
    checks++; if (oe_low !== 0) begin errors++; $display("FAIL wr_oe_low: got %0d expected 0", oe_low); end
    checks++; if (other_ack !== 0) begin errors++; $display("FAIL wr_z80_ack: got %0d pulses expected 0", other_ack); end
    checks++; if (mem[11'h7FF] !== 8'hA5) begin errors++; $display("FAIL wr_sram_content: got %h expected a5", mem[11'h7FF]); end
    tick();
    run_txn(1'b0, 1'b0, 11'h7FF, 8'h00, ack_cyc, oe_low, we_low, doe_cyc, first_we, other_ack, rdata);
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL wr_readback: got %h expected a5", rdata); end
    checks++; if (bus.HOST_RDATA !== 8'h00) begin errors++; $display("FAIL wr_host_rdata_untouched: got %h expected 00", bus.HOST_RDATA); end
    tick();
  endtask

  task automatic test_back_to_back();
    int order [4];
    int gaps [3];
    int nack, ngap, gap;
    bit seen_low;
    nack = 0; ngap = 0; gap = 0; seen_low = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int i = 0; i < 3; i++) gaps[i] = -1;
    do_reset();
    mem[11'h010] = 8'h5A;
    mem[11'h020] = 8'hC3;
    bus.Z80_WR = 1'b0;  bus.Z80_ADDR = 11'h010;
    bus.HOST_WR = 1'b0; bus.HOST_ADDR = 11'h020;
    bus.Z80_REQ = 1'b1; bus.HOST_REQ = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!bus.nCE) begin
        if (seen_low && gap > 0 && ngap < 3) begin gaps[ngap] = gap; ngap++; end
        seen_low = 1; gap = 0;
      end else if (seen_low) begin
        gap++;
      end
      if (bus.Z80_ACK && nack < 4) begin order[nack] = 0; nack++; end
      if (bus.HOST_ACK && nack < 4) begin order[nack] = 1; nack++; end
      if (nack == 4) begin
        bus.Z80_REQ = 1'b0; bus.HOST_REQ = 1'b0;
        break;
      end
    end
    checks++; if (order[0] !== 0) begin errors++; $display("FAIL rr_grant0: got %0d expected 0 (Z80)", order[0]); end
    checks++; if (order[1] !== 1) begin errors++; $display("FAIL rr_grant1: got %0d expected 1 (host)", order[1]); end
    checks++; if (order[2] !== 0) begin errors++; $display("FAIL rr_grant2: got %0d expected 0 (Z80)", order[2]); end
    checks++; if (order[3] !== 1) begin errors++; $display("FAIL rr_grant3: got %0d expected 1 (host)", order[3]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (gaps[i] !== 1) begin errors++; $display("FAIL rr_nce_gap%0d: got %0d expected 1", i, gaps[i]); end
    end
    checks++; if (bus.Z80_RDATA !== 8'h5A || bus.HOST_RDATA !== 8'hC3) begin errors++; $display("FAIL rr_rdata: got %h/%h expected 5a/c3", bus.Z80_RDATA, bus.HOST_RDATA); end
    for (int i = 0; i < 10 && bus.BUSY; i++) tick();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rr_return_idle: got busy=%b expected 0", bus.BUSY); end
  endtask

  task automatic test_reset_mid_write();
    int ack_cyc, oe_low, we_low, doe_cyc, first_we, other_ack, acks;
    logic [7:0] rdata;
    bit hit;
    hit = 0; acks = 0;
    bus.Z80_REQ = 1'b1; bus.Z80_WR = 1'b1; bus.Z80_ADDR = 11'h055; bus.Z80_WDATA = 8'h77;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.nWE) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_wr_reach_pulse: got no nWE pulse expected one"); end
    #2;
    RESET = 1'b1;
    bus.Z80_REQ = 1'b0;
    #1;
    checks++; if (bus.nWE !== 1'b1 || bus.nCE !== 1'b1 || bus.nOE !== 1'b1) begin errors++; $display("FAIL rst_wr_strobes: got nCE=%b nOE=%b nWE=%b expected 111", bus.nCE, bus.nOE, bus.nWE); end
    checks++; if (bus.RAM_DOE !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_wr_doe_busy: got doe=%b busy=%b expected 0/0", bus.RAM_DOE, bus.BUSY); end
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.Z80_ACK || bus.HOST_ACK) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_wr_no_ack: got %0d pulses expected 0", acks); end
    mem[11'h123] = 8'h23;
    run_txn(1'b0, 1'b0, 11'h123, 8'h00, ack_cyc, oe_low, we_low, doe_cyc, first_we, other_ack, rdata);
    checks++; if (ack_cyc !== 4 || oe_low !== 3) begin errors++; $display("FAIL rst_after_read_timing: got ack=%0d oe=%0d expected 4/3", ack_cyc, oe_low); end
    checks++; if (rdata !== 8'h23) begin errors++; $display("FAIL rst_after_read_data: got %h expected 23", rdata); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    bus.Z80_REQ = 1'b0;  bus.Z80_WR = 1'b0;  bus.Z80_ADDR = 11'd0;  bus.Z80_WDATA = 8'd0;
    bus.HOST_REQ = 1'b0; bus.HOST_WR = 1'b0; bus.HOST_ADDR = 11'd0; bus.HOST_WDATA = 8'd0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
    tick();
    test_reset();
    test_z80_read();
    test_host_write();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
